// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with double-buffered period/duty/burst
// configuration, continuous or triggered burst mode per channel.
module pwm_multi #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int BW  = 8,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           SysClk,
  input  logic           Reset,
  input  logic [NCH-1:0] Enable,
  input  logic           Load,
  input  logic [SW-1:0]  Sel,
  input  logic [CW-1:0]  Period,
  input  logic [CW-1:0]  Duty,
  input  logic [BW-1:0]  BurstLen,
  input  logic [NCH-1:0] Trigger,
  output logic [NCH-1:0] Pwm,
  output logic [NCH-1:0] Busy,
  output logic [NCH-1:0] Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BURST
  } st_e;

  // Holds every channel quiet for the first edge after reset release.
  logic arm_q;

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) arm_q <= 1'b0;
    else        arm_q <= 1'b1;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    st_e           st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pp_q, pp_d;
    logic [CW-1:0] pd_q, pd_d;
    logic [BW-1:0] pb_q, pb_d;
    logic [CW-1:0] ap_q, ap_d;
    logic [CW-1:0] ad_q, ad_d;
    logic [BW-1:0] ab_q, ab_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          pwm_q, pwm_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sel;
    logic          wrap;

    assign sel  = Load && (Sel == SW'(g));
    // A zero period wraps every clock so new settings still get picked up.
    assign wrap = (ap_q == '0) || (cnt_q == ap_q - CW'(1));

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      pp_d   = pp_q;
      pd_d   = pd_q;
      pb_d   = pb_q;
      ap_d   = ap_q;
      ad_d   = ad_q;
      ab_d   = ab_q;
      bcnt_d = bcnt_q;
      pwm_d  = pwm_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (arm_q) begin
        if (sel) begin
          pp_d = Period;
          pd_d = Duty;
          pb_d = BurstLen;
        end
        unique case (st_q)
          S_IDLE: begin
            if (Enable[g] && ((pb_q == '0) || Trigger[g])) begin
              st_d   = (pb_q == '0) ? S_RUN : S_BURST;
              cnt_d  = '0;
              bcnt_d = '0;
              ap_d   = pp_q;
              ad_d   = pd_q;
              ab_d   = pb_q;
            end
          end
          default: begin
            if (!Enable[g]) begin
              st_d   = S_IDLE;
              cnt_d  = '0;
              bcnt_d = '0;
            end else if (wrap) begin
              cnt_d = '0;
              ap_d  = pp_q;
              ad_d  = pd_q;
              // Burst length stays frozen for the burst in flight.
              if (st_q == S_BURST) begin
                if (bcnt_q == ab_q - BW'(1)) begin
                  st_d   = S_IDLE;
                  bcnt_d = '0;
                  done_d = 1'b1;
                end else begin
                  bcnt_d = bcnt_q + BW'(1);
                end
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        endcase
        busy_d = (st_d != S_IDLE);
        pwm_d  = busy_d && (ap_d != '0) && (cnt_d < ad_d);
      end
    end

    always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
        st_q   <= S_IDLE;
        cnt_q  <= '0;
        pp_q   <= '0;
        pd_q   <= '0;
        pb_q   <= '0;
        ap_q   <= '0;
        ad_q   <= '0;
        ab_q   <= '0;
        bcnt_q <= '0;
        pwm_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        pp_q   <= pp_d;
        pd_q   <= pd_d;
        pb_q   <= pb_d;
        ap_q   <= ap_d;
        ad_q   <= ad_d;
        ab_q   <= ab_d;
        bcnt_q <= bcnt_d;
        pwm_q  <= pwm_d;
        busy_q <= busy_d;
        done_q <= done_d;
      end
    end

    assign Pwm[g]  = pwm_q;
    assign Busy[g] = busy_q;
    assign Done[g] = done_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a cycle model predicts Pwm/Busy/Done,
// a monitor compares them one step after every rising edge.
module tb_pwm_multi;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int BW  = 8;
  localparam int SW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic [NCH-1:0] trig = '0;
  logic           load = 1'b0;
  logic [SW-1:0]  sel = '0;
  logic [CW-1:0]  per = '0;
  logic [CW-1:0]  duty = '0;
  logic [BW-1:0]  blen = '0;
  logic [NCH-1:0] pwm, busy, done;

  always #5 clk = ~clk;

  pwm_multi #(.NCH(NCH), .CW(CW), .BW(BW)) dut (
    .SysClk(clk), .Reset(rst_n), .Enable(en), .Load(load), .Sel(sel),
    .Period(per), .Duty(duty), .BurstLen(blen), .Trigger(trig),
    .Pwm(pwm), .Busy(busy), .Done(done)
  );

  typedef struct packed {
    logic [NCH-1:0] p;
    logic [NCH-1:0] b;
    logic [NCH-1:0] d;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: pending/active config, mode 0 idle 1 run 2 burst,
  // position inside the period and completed periods of a burst.
  int mP[NCH], mD[NCH], mB[NCH];
  int aP[NCH], aD[NCH], aB[NCH];
  int mode[NCH], pos[NCH], nper[NCH];
  bit armed;

  function automatic void check(string nm, int act, int want);
    checks++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
  endfunction

  function automatic void model_reset();
    armed = 0;
    for (int c = 0; c < NCH; c++) begin
      mP[c] = 0; mD[c] = 0; mB[c] = 0;
      aP[c] = 0; aD[c] = 0; aB[c] = 0;
      mode[c] = 0; pos[c] = 0; nper[c] = 0;
    end
  endfunction

  function automatic exp_t model_step();
    exp_t e;
    e = '0;
    if (!rst_n) begin
      model_reset();
      return e;
    end
    if (!armed) begin
      armed = 1;
      return e;
    end
    for (int c = 0; c < NCH; c++) begin
      bit dn;
      dn = 0;
      if (mode[c] == 0) begin
        if (en[c] && (mB[c] == 0 || trig[c])) begin
          mode[c] = (mB[c] == 0) ? 1 : 2;
          pos[c] = 0; nper[c] = 0;
          aP[c] = mP[c]; aD[c] = mD[c]; aB[c] = mB[c];
        end
      end else if (!en[c]) begin
        mode[c] = 0;
      end else if (aP[c] == 0 || pos[c] + 1 >= aP[c]) begin
        pos[c] = 0;
        aP[c] = mP[c]; aD[c] = mD[c];
        if (mode[c] == 2) begin
          nper[c]++;
          if (nper[c] == aB[c]) begin
            mode[c] = 0;
            dn = 1;
          end
        end
      end else begin
        pos[c]++;
      end
      if (load && int'(sel) == c) begin
        mP[c] = int'(per); mD[c] = int'(duty); mB[c] = int'(blen);
      end
      e.p[c] = (mode[c] != 0) && (aP[c] > 0) && (pos[c] < aD[c]);
      e.b[c] = (mode[c] != 0);
      e.d[c] = dn;
    end
    return e;
  endfunction

  task automatic tick();
    q.push_back(model_step());
    @(negedge clk);
  endtask

  task automatic do_load(int ch, int p, int d, int b);
    sel = SW'(ch); per = CW'(p); duty = CW'(d); blen = BW'(b);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pwm", int'(pwm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pwm", int'(pwm), int'(e.p));
        check("busy", int'(busy), int'(e.b));
        check("done", int'(done), int'(e.d));
      end
    end
  end

  initial begin : stim
    int h, dn, at;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_pwm", int'(pwm), 0);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    rst_n = 1'b1;
    tick();

    do_load(0, 10, 3, 0);
    en[0] = 1'b1;
    h = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      h += int'(pwm[0]);
    end
    check("ch0_high_20", h, 6);
    check("ch0_busy", int'(busy[0]), 1);
    repeat (6) tick();
    do_load(0, 10, 7, 0);
    h = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      h += int'(pwm[0]);
    end
    check("ch0_new_duty", h, 7);

    en[0] = 1'b0;
    do_load(1, 4, 2, 3);
    en[1] = 1'b1;
    tick();
    trig[1] = 1'b1;
    h = 0; dn = 0; at = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      trig[1] = 1'b0;
      h += int'(pwm[1]);
      dn += int'(done[1]);
      if (done[1]) at = i;
    end
    check("burst_high", h, 6);
    check("burst_done_cnt", dn, 1);
    check("burst_done_edge", at, 12);
    check("burst_busy_after", int'(busy[1]), 0);
    en[1] = 1'b0;

    do_load(2, 8, 0, 0);
    en[2] = 1'b1;
    repeat (10) tick();
    do_load(2, 8, 8, 0);
    repeat (20) tick();
    check("d_eq_p_high", int'(pwm[2]), 1);
    do_load(2, 0, 5, 0);
    repeat (10) tick();
    check("p0_low", int'(pwm[2]), 0);
    check("p0_busy", int'(busy[2]), 1);
    en[2] = 1'b0;

    do_load(3, 4, 2, 5);
    en[3] = 1'b1;
    trig[3] = 1'b1;
    tick();
    trig[3] = 1'b0;
    repeat (5) tick();
    en[3] = 1'b0;
    do_reset();
    tick();
    do_load(3, 4, 2, 5);
    en[3] = 1'b1;
    trig[3] = 1'b1;
    h = 0; dn = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      trig[3] = 1'b0;
      h += int'(pwm[3]);
      dn += int'(done[3]);
    end
    check("rburst_high", h, 10);
    check("rburst_done", dn, 1);
    en = '0;
    tick();

    do_load(0, 5, 2, 0);
    do_load(1, 7, 3, 0);
    do_load(2, 6, 4, 3);
    do_load(3, 9, 9, 0);
    en = '1;
    trig[2] = 1'b1;
    tick();
    trig[2] = 1'b0;
    repeat (6) tick();
    trig[2] = 1'b1;
    tick();
    trig[2] = 1'b0;
    repeat (40) tick();
    en = '0;
    tick();

    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 29) == 0) en[c] = ~en[c];
        trig[c] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        sel  = SW'($urandom_range(0, NCH - 1));
        per  = CW'($urandom_range(0, 12));
        duty = CW'($urandom_range(0, 14));
        blen = BW'($urandom_range(0, 3));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) begin
        load = 1'b0;
        do_reset();
      end
      tick();
    end
    load = 1'b0;
    trig = '0;
    en = '0;
    repeat (3) tick();
    repeat (2) @(negedge clk);
    check("queue_drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
